// File: rtl/gb_pkg.sv
// Shared definitions for the interrupt controller: default register
// addresses, FSM state encoding and the priority helper.
package gb_pkg;

  localparam logic [15:0] GB_IF_ADDR = 16'hFF0F;
  localparam logic [15:0] GB_IE_ADDR = 16'hFFFF;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } gb_state_e;

  // Lowest set bit wins; returns 0 for an empty vector.
  function automatic logic [2:0] lowest_set(input logic [7:0] vec);
    logic [2:0] idx;
    idx = '0;
    for (int i = 7; i >= 0; i--) begin
      if (vec[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/gb_intc_chan.sv
// One interrupt channel: edge or level detection plus its IF bit.
// In the same cycle a hardware set beats a store-clear, which beats nothing.
module gb_intc_chan
  import gb_pkg::*;
#(
  parameter bit LEVEL = 1'b0
) (
  input  logic clock,
  input  logic resetn,
  input  logic irq,
  input  logic wr_en,
  input  logic wr_val,
  input  logic ack_clr,
  output logic flag
);

  logic prev_q;
  logic flag_q, flag_d;
  logic hw_set;

  assign hw_set = LEVEL ? irq : (irq & ~prev_q);

  // Store applies first, then the acknowledge clear, then the hardware set.
  always_comb begin
    flag_d = flag_q;
    if (wr_en)   flag_d = wr_val;
    if (ack_clr) flag_d = 1'b0;
    if (hw_set)  flag_d = 1'b1;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      prev_q <= 1'b0;
      flag_q <= 1'b0;
    end else begin
      prev_q <= irq;
      flag_q <= flag_d;
    end
  end

  assign flag = flag_q;

endmodule

// File: rtl/gb_intc.sv
// Game-Boy style interrupt controller: IF/IE registers on the CPU bus,
// fixed lowest-index priority, and a two-state request/acknowledge FSM.
module gb_intc
  import gb_pkg::*;
#(
  parameter int          NUM_IRQ    = 5,
  parameter logic [15:0] VEC_BASE   = 16'h0040,
  parameter logic [15:0] VEC_STRIDE = 16'h0008,
  parameter logic [7:0]  LEVEL_MASK = 8'h00,
  parameter logic [15:0] IF_ADDR    = GB_IF_ADDR,
  parameter logic [15:0] IE_ADDR    = GB_IE_ADDR
) (
  input  logic               clock,
  input  logic               resetn,
  input  logic [15:0]        address,
  input  logic [7:0]         wdata,
  input  logic               store,
  input  logic               load,
  output logic [7:0]         rdata,
  input  logic [NUM_IRQ-1:0] irq_in,
  output logic               intreq,
  output logic [15:0]        intaddress,
  input  logic               intack,
  output logic               wake
);

  logic [NUM_IRQ-1:0] if_bits;
  logic [NUM_IRQ-1:0] ie_q, ie_d;
  logic [NUM_IRQ-1:0] ack_clr;
  logic [7:0]         if8, ie8, pend8, ack8, rd;
  logic               wr_if, wr_ie;
  logic [2:0]         first_idx;
  logic [15:0]        vec_next;

  gb_state_e   state_q;
  logic        intreq_q;
  logic [15:0] intaddress_q;
  logic [2:0]  idx_q;

  assign wr_if = store && (address == IF_ADDR);
  assign wr_ie = store && (address == IE_ADDR);

  for (genvar i = 0; i < NUM_IRQ; i++) begin : g_chan
    gb_intc_chan #(
      .LEVEL(LEVEL_MASK[i])
    ) u_chan (
      .clock  (clock),
      .resetn (resetn),
      .irq    (irq_in[i]),
      .wr_en  (wr_if),
      .wr_val (wdata[i]),
      .ack_clr(ack_clr[i]),
      .flag   (if_bits[i])
    );
  end

  always_comb begin
    ie_d = ie_q;
    if (wr_ie) ie_d = wdata[NUM_IRQ-1:0];
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) ie_q <= '0;
    else         ie_q <= ie_d;
  end

  // Widen to 8 bits so the latched index can address any bit directly.
  always_comb begin
    if8 = '0;
    ie8 = '0;
    if8[NUM_IRQ-1:0] = if_bits;
    ie8[NUM_IRQ-1:0] = ie_q;
  end

  assign pend8     = if8 & ie8;
  assign first_idx = lowest_set(pend8);
  assign vec_next  = VEC_BASE + 16'(first_idx) * VEC_STRIDE;
  assign wake      = |pend8;

  assign ack8    = (state_q == ST_REQ && intack) ? (8'b1 << idx_q) : 8'h00;
  assign ack_clr = ack8[NUM_IRQ-1:0];

  always_comb begin
    rd = 8'h00;
    if (load && address == IF_ADDR) begin
      rd = 8'hFF;
      rd[NUM_IRQ-1:0] = if_bits;
    end else if (load && address == IE_ADDR) begin
      rd = 8'hFF;
      rd[NUM_IRQ-1:0] = ie_q;
    end
  end

  assign rdata = rd;

  // Request holds stable until acknowledged or its source is cleared by software.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q      <= ST_IDLE;
      intreq_q     <= 1'b0;
      intaddress_q <= VEC_BASE;
      idx_q        <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (|pend8) begin
            idx_q        <= first_idx;
            intaddress_q <= vec_next;
            intreq_q     <= 1'b1;
            state_q      <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (intack || !(if8[idx_q] && ie8[idx_q])) begin
            intreq_q <= 1'b0;
            state_q  <= ST_IDLE;
          end
        end
        default: begin
          intreq_q <= 1'b0;
          state_q  <= ST_IDLE;
        end
      endcase
    end
  end

  assign intreq     = intreq_q;
  assign intaddress = intaddress_q;

endmodule

// File: tb/tb_gb_intc.sv
// Directed bench for gb_intc with channel 0 level-sensitive, channels 1..4 edge.
module tb_gb_intc;

  localparam logic [15:0] IFA = 16'hFF0F;
  localparam logic [15:0] IEA = 16'hFFFF;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic [15:0] address = 16'h0000;
  logic [7:0]  wdata = 8'h00;
  logic        store = 1'b0;
  logic        load = 1'b0;
  logic [7:0]  rdata;
  logic [4:0]  irq_in = 5'h00;
  logic        intreq;
  logic [15:0] intaddress;
  logic        intack = 1'b0;
  logic        wake;

  int errors = 0;
  int checks = 0;
  logic [7:0] rv;

  gb_intc #(
    .NUM_IRQ   (5),
    .VEC_BASE  (16'h0040),
    .VEC_STRIDE(16'h0008),
    .LEVEL_MASK(8'h01),
    .IF_ADDR   (IFA),
    .IE_ADDR   (IEA)
  ) dut (
    .clock     (clock),
    .resetn    (resetn),
    .address   (address),
    .wdata     (wdata),
    .store     (store),
    .load      (load),
    .rdata     (rdata),
    .irq_in    (irq_in),
    .intreq    (intreq),
    .intaddress(intaddress),
    .intack    (intack),
    .wake      (wake)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
    address = a;
    wdata   = d;
    store   = 1'b1;
    tick();
    store   = 1'b0;
  endtask

  task automatic bus_read(input logic [15:0] a, output logic [7:0] d);
    address = a;
    load    = 1'b1;
    #1;
    d       = rdata;
    load    = 1'b0;
  endtask

  task automatic ack_cycle();
    intack = 1'b1;
    tick();
    intack = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    tick();
    tick();
    checks++; if (intreq !== 1'b0) begin errors++; $display("FAIL reset_intreq: got %b expected 0", intreq); end
    checks++; if (intaddress !== 16'h0040) begin errors++; $display("FAIL reset_intaddress: got %h expected 0040", intaddress); end
    checks++; if (wake !== 1'b0) begin errors++; $display("FAIL reset_wake: got %b expected 0", wake); end
    bus_read(IFA, rv);
    checks++; if (rv !== 8'hE0) begin errors++; $display("FAIL reset_if: got %h expected e0", rv); end
    bus_read(IEA, rv);
    checks++; if (rv !== 8'hE0) begin errors++; $display("FAIL reset_ie: got %h expected e0", rv); end
    address = IFA;
    load = 1'b0;
    #1;
    checks++; if (rdata !== 8'h00) begin errors++; $display("FAIL rdata_no_load: got %h expected 00", rdata); end
    resetn = 1'b1;
    tick();
  endtask

  task automatic test_single();
    bus_write(IEA, 8'h1F);
    irq_in = 5'b00100;
    tick();
    irq_in = 5'b00000;
    checks++; if (intreq !== 1'b0) begin errors++; $display("FAIL single_early: got %b expected 0", intreq); end
    bus_read(IFA, rv);
    checks++; if (rv !== 8'hE4) begin errors++; $display("FAIL single_if_set: got %h expected e4", rv); end
    tick();
    checks++; if (intreq !== 1'b1) begin errors++; $display("FAIL single_intreq: got %b expected 1", intreq); end
    checks++; if (intaddress !== 16'h0050) begin errors++; $display("FAIL single_vector: got %h expected 0050", intaddress); end
    checks++; if (wake !== 1'b1) begin errors++; $display("FAIL single_wake: got %b expected 1", wake); end
    ack_cycle();
    checks++; if (intreq !== 1'b0) begin errors++; $display("FAIL single_ack_intreq: got %b expected 0", intreq); end
    bus_read(IFA, rv);
    checks++; if (rv !== 8'hE0) begin errors++; $display("FAIL single_ack_if: got %h expected e0", rv); end
  endtask

  task automatic test_priority();
    irq_in = 5'b01010;
    tick();
    irq_in = 5'b00000;
    tick();
    checks++; if (intreq !== 1'b1) begin errors++; $display("FAIL prio_first_req: got %b expected 1", intreq); end
    checks++; if (intaddress !== 16'h0048) begin errors++; $display("FAIL prio_first_vec: got %h expected 0048", intaddress); end
    ack_cycle();
    checks++; if (intreq !== 1'b0) begin errors++; $display("FAIL prio_gap: got %b expected 0", intreq); end
    bus_read(IFA, rv);
    checks++; if (rv !== 8'hE8) begin errors++; $display("FAIL prio_if_after_ack: got %h expected e8", rv); end
    tick();
    checks++; if (intreq !== 1'b1) begin errors++; $display("FAIL prio_second_req: got %b expected 1", intreq); end
    checks++; if (intaddress !== 16'h0058) begin errors++; $display("FAIL prio_second_vec: got %h expected 0058", intaddress); end
    ack_cycle();
    checks++; if (intreq !== 1'b0) begin errors++; $display("FAIL prio_done: got %b expected 0", intreq); end
  endtask

  task automatic test_masked();
    bus_write(IEA, 8'h00);
    irq_in = 5'b00001;
    tick();
    irq_in = 5'b00000;
    tick();
    checks++; if (intreq !== 1'b0) begin errors++; $display("FAIL masked_intreq: got %b expected 0", intreq); end
    checks++; if (wake !== 1'b0) begin errors++; $display("FAIL masked_wake: got %b expected 0", wake); end
    bus_read(IFA, rv);
    checks++; if (rv !== 8'hE1) begin errors++; $display("FAIL masked_if: got %h expected e1", rv); end
    ack_cycle();
    bus_read(IFA, rv);
    checks++; if (rv !== 8'hE1) begin errors++; $display("FAIL idle_ack_ignored: got %h expected e1", rv); end
    bus_write(IEA, 8'h01);
    checks++; if (intreq !== 1'b0) begin errors++; $display("FAIL enable_same_edge: got %b expected 0", intreq); end
    checks++; if (wake !== 1'b1) begin errors++; $display("FAIL enable_wake: got %b expected 1", wake); end
    tick();
    checks++; if (intreq !== 1'b1) begin errors++; $display("FAIL enable_intreq: got %b expected 1", intreq); end
    checks++; if (intaddress !== 16'h0040) begin errors++; $display("FAIL enable_vec: got %h expected 0040", intaddress); end
    ack_cycle();
    bus_read(IFA, rv);
    checks++; if (rv !== 8'hE0) begin errors++; $display("FAIL enable_ack_if: got %h expected e0", rv); end
  endtask

  task automatic test_sw_clear();
    bus_write(IEA, 8'h1F);
    irq_in = 5'b00100;
    tick();
    tick();
    checks++; if (intreq !== 1'b1) begin errors++; $display("FAIL swclr_req: got %b expected 1", intreq); end
    bus_write(IFA, 8'h00);
    tick();
    checks++; if (intreq !== 1'b0) begin errors++; $display("FAIL swclr_drop: got %b expected 0", intreq); end
    tick();
    tick();
    checks++; if (intreq !== 1'b0) begin errors++; $display("FAIL swclr_no_retrigger: got %b expected 0", intreq); end
    bus_read(IFA, rv);
    checks++; if (rv !== 8'hE0) begin errors++; $display("FAIL swclr_if: got %h expected e0", rv); end
    irq_in = 5'b00000;
    tick();
  endtask

  task automatic test_no_relatch();
    irq_in = 5'b10000;
    tick();
    irq_in = 5'b00000;
    tick();
    checks++; if (intaddress !== 16'h0060) begin errors++; $display("FAIL relatch_first_vec: got %h expected 0060", intaddress); end
    irq_in = 5'b00001;
    tick();
    irq_in = 5'b00000;
    tick();
    checks++; if (intreq !== 1'b1) begin errors++; $display("FAIL relatch_hold_req: got %b expected 1", intreq); end
    checks++; if (intaddress !== 16'h0060) begin errors++; $display("FAIL relatch_hold_vec: got %h expected 0060", intaddress); end
    ack_cycle();
    checks++; if (intreq !== 1'b0) begin errors++; $display("FAIL relatch_gap: got %b expected 0", intreq); end
    tick();
    checks++; if (intaddress !== 16'h0040) begin errors++; $display("FAIL relatch_next_vec: got %h expected 0040", intaddress); end
    ack_cycle();
    bus_read(IFA, rv);
    checks++; if (rv !== 8'hE0) begin errors++; $display("FAIL relatch_if: got %h expected e0", rv); end
  endtask

  task automatic test_level();
    irq_in = 5'b00001;
    tick();
    tick();
    checks++; if (intreq !== 1'b1) begin errors++; $display("FAIL level_req: got %b expected 1", intreq); end
    ack_cycle();
    checks++; if (intreq !== 1'b0) begin errors++; $display("FAIL level_gap: got %b expected 0", intreq); end
    bus_read(IFA, rv);
    checks++; if (rv !== 8'hE1) begin errors++; $display("FAIL level_if_kept: got %h expected e1", rv); end
    tick();
    checks++; if (intreq !== 1'b1) begin errors++; $display("FAIL level_rereq: got %b expected 1", intreq); end
    irq_in = 5'b00011;
    bus_write(IFA, 8'h00);
    bus_read(IFA, rv);
    checks++; if (rv !== 8'hE3) begin errors++; $display("FAIL set_beats_store: got %h expected e3", rv); end
    checks++; if (intaddress !== 16'h0040) begin errors++; $display("FAIL level_vec_stable: got %h expected 0040", intaddress); end
    irq_in = 5'b00000;
    ack_cycle();
    bus_read(IFA, rv);
    checks++; if (rv !== 8'hE2) begin errors++; $display("FAIL level_ack_if: got %h expected e2", rv); end
    tick();
    checks++; if (intaddress !== 16'h0048) begin errors++; $display("FAIL level_next_vec: got %h expected 0048", intaddress); end
  endtask

  task automatic test_reset_mid();
    checks++; if (intreq !== 1'b1) begin errors++; $display("FAIL rstmid_pre: got %b expected 1", intreq); end
    resetn = 1'b0;
    #1;
    checks++; if (intreq !== 1'b0) begin errors++; $display("FAIL rstmid_async_drop: got %b expected 0", intreq); end
    checks++; if (intaddress !== 16'h0040) begin errors++; $display("FAIL rstmid_vec: got %h expected 0040", intaddress); end
    bus_read(IFA, rv);
    checks++; if (rv !== 8'hE0) begin errors++; $display("FAIL rstmid_if: got %h expected e0", rv); end
    bus_read(IEA, rv);
    checks++; if (rv !== 8'hE0) begin errors++; $display("FAIL rstmid_ie: got %h expected e0", rv); end
    tick();
    resetn = 1'b1;
    tick();
    tick();
    checks++; if (intreq !== 1'b0) begin errors++; $display("FAIL rstmid_no_pending: got %b expected 0", intreq); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_priority();
    test_masked();
    test_sw_clear();
    test_no_relatch();
    test_level();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/gb_intc.md
GB_INTC -- requirements
Module: gb_intc

Interface
REQ-001 Parameter NUM_IRQ, default 5, SHALL set the number of interrupt channels (legal range 1..8).
REQ-002 Parameter VEC_BASE, default 16'h0040, SHALL be the vector of channel 0.
REQ-003 Parameter VEC_STRIDE, default 16'h0008, SHALL be the vector spacing between consecutive channels.
REQ-004 Parameter LEVEL_MASK, default 8'h00, SHALL select per channel: bit=1 level-sensitive, bit=0 rising-edge.
REQ-005 Parameter IF_ADDR, default 16'hFF0F, SHALL be the flag register address.
REQ-006 Parameter IE_ADDR, default 16'hFFFF, SHALL be the enable register address.
REQ-007 Port clock, input, 1: the single clock; all state SHALL update on its rising edge.
REQ-008 Port resetn, input, 1: reset, asynchronous, active-low.
REQ-009 Port address, input, 16: CPU bus address.
REQ-010 Port wdata, input, 8: CPU write data.
REQ-011 Port store, input, 1: write strobe, one cycle per write.
REQ-012 Port load, input, 1: read strobe.
REQ-013 Port rdata, output, 8: read data, combinational.
REQ-014 Port irq_in, input, NUM_IRQ: interrupt sources, synchronous to clock.
REQ-015 Port intreq, output, 1: interrupt request to the CPU core, registered.
REQ-016 Port intaddress, output, 16: vector of the requested channel, registered.
REQ-017 Port intack, input, 1: one-cycle acknowledge from the CPU core.
REQ-018 Port wake, output, 1: combinational |(IF & IE), used for HALT exit.

Function
REQ-019 Edge channel: IF[i] SHALL set on the edge after irq_in[i] is sampled high while the previous sample was low. Level channel: IF[i] SHALL set on every edge where irq_in[i] is sampled high.
REQ-020 store with address==IF_ADDR SHALL write IF[NUM_IRQ-1:0] from wdata. store with address==IE_ADDR SHALL write IE[NUM_IRQ-1:0] from wdata.
REQ-021 Unimplemented IF/IE bits SHALL read 1. rdata SHALL be {1s, IF} or {1s, IE} when load and the address matches, and 8'h00 otherwise.
REQ-022 FSM states: IDLE and REQ. In IDLE, if (IF & IE) != 0, the FSM SHALL latch idx = the lowest set index, set intaddress = VEC_BASE + idx*VEC_STRIDE (16-bit wrap), assert intreq, and enter REQ.
REQ-023 Request latency: an edge on irq_in sampled at edge k with IE set SHALL give intreq=1 after edge k+1.
REQ-024 In REQ, intreq and intaddress SHALL hold stable. A higher-priority arrival SHALL NOT re-latch.
REQ-025 In REQ with intack=1: IF[idx] SHALL clear, intreq SHALL deassert, and the FSM SHALL return to IDLE. Consecutive requests are therefore separated by at least one intreq-low cycle.
REQ-026 In REQ, if IF[idx] or IE[idx] reads 0 (cleared by software) and intack=0, the FSM SHALL deassert intreq and return to IDLE on the next edge.
REQ-027 intack in IDLE SHALL be ignored.
REQ-028 Same-cycle priority on an IF bit: a hardware set SHALL override both a store-clear and an intack-clear. A store to IF SHALL apply before the intack clear.
REQ-029 wake SHALL be independent of FSM state and of intack.

Reset
REQ-030 While resetn is low: IF=0, IE=0, edge history=0, intreq=0, intaddress=VEC_BASE, FSM=IDLE.
REQ-031 Reset asserted mid-REQ SHALL drop intreq immediately (asynchronously). No pending flag SHALL survive reset.

Structure
REQ-032 Shared package gb_pkg SHALL hold IF_ADDR/IE_ADDR defaults and the FSM state encoding.
REQ-033 One sub-module, gb_intc_chan (per-channel edge/level detect plus IF bit set/clear), SHALL be instantiated NUM_IRQ times.

Verification
REQ-034 Reset, then IE=5'h1F and a pulse on irq_in[2] -> intreq=1 two edges later, intaddress=16'h0050. intack -> IF=5'h00, intreq=0.
REQ-035 irq_in[1] and irq_in[3] rising in the same cycle, IE=5'h1F -> first vector 16'h0048. After ack, an idle cycle, then 16'h0058.
REQ-036 IF bit set with IE=0 -> intreq stays 0, wake=0, and a read of IF_ADDR gives 8'hE1 (channel 0). Then write IE=1 -> intreq after 1 edge.
REQ-037 In REQ, store IF=0 with no intack -> intreq=0 next edge. A held-high edge channel SHALL NOT re-trigger.
REQ-038 Level channel (LEVEL_MASK=8'h01) held high, intack asserted -> IF[0] stays 1 and a new request follows after the idle cycle. Same-cycle irq edge and store-clear -> bit remains set.
REQ-039 resetn pulsed low while intreq=1 -> intreq=0 asynchronously, IF=IE=0, intaddress=16'h0040.
